// File: rtl/spi_flash_host.sv
// SPI NOR-flash read host: opcode/address out on io[0], optional dummy cycles, then data in
// over 1/2/4 rails, delivered as a valid/ready byte stream whose backpressure stalls sck.
module spi_flash_host #(
  parameter int CLK_DIV = 2,
  parameter int LEN_W   = 16
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_opcode,
  input  logic             cmd_has_addr,
  input  logic [23:0]      cmd_addr,
  input  logic [3:0]       cmd_dummy,
  input  logic [1:0]       cmd_mode,
  input  logic [LEN_W-1:0] cmd_len,
  output logic [7:0]       rdata,
  output logic             rdata_valid,
  input  logic             rdata_ready,
  output logic             busy,
  output logic             sck,
  output logic             cs_n,
  output logic [3:0]       io_out,
  output logic [3:0]       io_oe,
  input  logic [3:0]       io_in
);
  localparam int DIV_W = $clog2(2*CLK_DIV + 1);
  localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] HOLD_LAST = DIV_W'(2*CLK_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_END, S_HOLD} state_t;

  state_t           r_state, w_state_nxt, w_after, w_post_addr, w_post_dummy;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic [4:0]       r_cnt, w_cnt_nxt, w_grp_last;
  logic [LEN_W-1:0] r_bytes, w_bytes_nxt, r_len, w_len_nxt;
  logic [31:0]      r_tx, w_tx_nxt;
  logic [7:0]       r_rx, w_rx_nxt, r_rdata, w_rdata_nxt, w_rx_shift;
  logic             r_has_addr, w_has_addr_nxt;
  logic [3:0]       r_dummy, w_dummy_nxt;
  logic [1:0]       r_mode, w_mode_nxt;
  logic             r_sck, w_sck_nxt, r_cs_n, w_cs_n_nxt;
  logic             r_rdata_valid, w_rdata_valid_nxt, r_busy, w_busy_nxt;
  logic [3:0]       r_io_out, w_io_out_nxt, r_io_oe, w_io_oe_nxt;
  logic             w_stall, w_done;

  assign w_post_dummy = (r_len != '0) ? S_DATA : S_END;
  assign w_post_addr  = (r_dummy != 4'd0) ? S_DUMMY : w_post_dummy;

  always_comb begin
    case (r_mode)
      2'd1:    begin w_rx_shift = {r_rx[5:0], io_in[1:0]}; w_grp_last = 5'd3; end
      2'd2:    begin w_rx_shift = {r_rx[3:0], io_in};      w_grp_last = 5'd1; end
      default: begin w_rx_shift = {r_rx[6:0], io_in[1]};   w_grp_last = 5'd7; end
    endcase
  end

  always_comb begin
    w_done  = 1'b0;
    w_after = S_END;
    case (r_state)
      S_CMD:   begin w_done = (r_cnt == 5'd8);  w_after = r_has_addr ? S_ADDR : w_post_addr; end
      S_ADDR:  begin w_done = (r_cnt == 5'd24); w_after = w_post_addr; end
      S_DUMMY: begin w_done = (r_cnt == {1'b0, r_dummy}); w_after = w_post_dummy; end
      S_DATA:  begin w_done = (r_bytes == r_len); w_after = S_END; end
      default: ;
    endcase
  end

  // A byte-completing rise with the output byte still unconsumed would overwrite it: hold sck low.
  assign w_stall = (r_state == S_DATA) && !r_sck && (r_cnt == w_grp_last) &&
                   r_rdata_valid && !rdata_ready;

  always_comb begin
    w_state_nxt       = r_state;
    w_div_nxt         = r_div;
    w_cnt_nxt         = r_cnt;
    w_bytes_nxt       = r_bytes;
    w_len_nxt         = r_len;
    w_tx_nxt          = r_tx;
    w_rx_nxt          = r_rx;
    w_rdata_nxt       = r_rdata;
    w_has_addr_nxt    = r_has_addr;
    w_dummy_nxt       = r_dummy;
    w_mode_nxt        = r_mode;
    w_sck_nxt         = r_sck;
    w_cs_n_nxt        = r_cs_n;
    w_io_out_nxt      = r_io_out;
    w_io_oe_nxt       = r_io_oe;
    w_rdata_valid_nxt = r_rdata_valid;
    if (r_rdata_valid && rdata_ready) w_rdata_valid_nxt = 1'b0;
    case (r_state)
      S_IDLE: if (cmd_valid) begin
        w_state_nxt    = S_CMD;
        w_has_addr_nxt = cmd_has_addr;
        w_dummy_nxt    = cmd_dummy;
        w_mode_nxt     = cmd_mode;
        w_len_nxt      = cmd_len;
        w_tx_nxt       = {cmd_opcode[6:0], cmd_addr, 1'b0};
        w_io_out_nxt   = {3'b000, cmd_opcode[7]};
        w_io_oe_nxt    = 4'b0001;
        w_cs_n_nxt     = 1'b0;
        w_sck_nxt      = 1'b0;
        w_div_nxt      = '0;
        w_cnt_nxt      = '0;
        w_bytes_nxt    = '0;
      end
      S_CMD, S_ADDR, S_DUMMY, S_DATA: if (!w_stall) begin
        if (r_div != HALF_LAST) begin
          w_div_nxt = r_div + DIV_W'(1);
        end else begin
          w_div_nxt = '0;
          w_sck_nxt = !r_sck;
          if (!r_sck) begin
            w_cnt_nxt = r_cnt + 5'd1;
            if (r_state == S_DATA) begin
              w_rx_nxt = w_rx_shift;
              if (r_cnt == w_grp_last) begin
                w_cnt_nxt         = '0;
                w_bytes_nxt       = r_bytes + LEN_W'(1);
                w_rdata_nxt       = w_rx_shift;
                w_rdata_valid_nxt = 1'b1;
              end
            end
          end else begin
            // Falling edge: advance phase if complete, then present the next output bit.
            if (w_done) begin
              w_state_nxt = w_after;
              w_cnt_nxt   = '0;
            end
            if (w_state_nxt == S_CMD || w_state_nxt == S_ADDR) begin
              w_io_out_nxt = {3'b000, r_tx[31]};
              w_tx_nxt     = {r_tx[30:0], 1'b0};
            end else begin
              w_io_out_nxt = '0;
              w_io_oe_nxt  = '0;
            end
          end
        end
      end
      S_END: begin
        w_div_nxt = r_div + DIV_W'(1);
        if (r_div == HALF_LAST) begin
          w_div_nxt   = '0;
          w_cs_n_nxt  = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        w_div_nxt = r_div + DIV_W'(1);
        if (r_div == HOLD_LAST) begin
          w_div_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_state       <= S_IDLE;
      r_div         <= '0;
      r_cnt         <= '0;
      r_bytes       <= '0;
      r_len         <= '0;
      r_tx          <= '0;
      r_rx          <= '0;
      r_rdata       <= '0;
      r_has_addr    <= 1'b0;
      r_dummy       <= '0;
      r_mode        <= '0;
      r_sck         <= 1'b0;
      r_cs_n        <= 1'b1;
      r_io_out      <= '0;
      r_io_oe       <= '0;
      r_rdata_valid <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_div         <= w_div_nxt;
      r_cnt         <= w_cnt_nxt;
      r_bytes       <= w_bytes_nxt;
      r_len         <= w_len_nxt;
      r_tx          <= w_tx_nxt;
      r_rx          <= w_rx_nxt;
      r_rdata       <= w_rdata_nxt;
      r_has_addr    <= w_has_addr_nxt;
      r_dummy       <= w_dummy_nxt;
      r_mode        <= w_mode_nxt;
      r_sck         <= w_sck_nxt;
      r_cs_n        <= w_cs_n_nxt;
      r_io_out      <= w_io_out_nxt;
      r_io_oe       <= w_io_oe_nxt;
      r_rdata_valid <= w_rdata_valid_nxt;
      r_busy        <= w_busy_nxt;
    end
  end

  assign cmd_ready   = (r_state == S_IDLE);
  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;
  assign busy        = r_busy;
  assign sck         = r_sck;
  assign cs_n        = r_cs_n;
  assign io_out      = r_io_out;
  assign io_oe       = r_io_oe;
endmodule

// File: tb/tb_spi_flash_host.sv
// Bench for spi_flash_host: a flash responder model drives io_in from a byte list, a monitor
// counts sck edges and collects delivered bytes, and directed plus random reads are checked.
module tb_spi_flash_host;
  localparam int CLK_DIV = 2;
  localparam int LEN_W   = 16;

  logic             clk = 1'b0, rst_b = 1'b0;
  logic             cmd_valid = 1'b0, cmd_ready;
  logic [7:0]       cmd_opcode = '0;
  logic             cmd_has_addr = 1'b0;
  logic [23:0]      cmd_addr = '0;
  logic [3:0]       cmd_dummy = '0;
  logic [1:0]       cmd_mode = '0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic [7:0]       rdata;
  logic             rdata_valid, rdata_ready = 1'b1;
  logic             busy, sck, cs_n;
  logic [3:0]       io_out, io_oe, io_in = '0;

  spi_flash_host #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_b(rst_b), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_has_addr(cmd_has_addr), .cmd_addr(cmd_addr),
    .cmd_dummy(cmd_dummy), .cmd_mode(cmd_mode), .cmd_len(cmd_len),
    .rdata(rdata), .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .busy(busy),
    .sck(sck), .cs_n(cs_n), .io_out(io_out), .io_oe(io_oe), .io_in(io_in)
  );

  always #5 clk = ~clk;

  int nvec = 0, nfail = 0;
  int cyc = 0, nrises = 0, oe_bad = 0, vcount = 0, ready_mode = 0;
  int t_csfall = -1, t_csrise = -1, t_first_rise = -1, t_last_fall = -1, t_ready = -1;
  logic [31:0] tx_val = '0;
  logic [7:0]  rx_q[$];
  logic [7:0]  m_data[$];
  int          m_pre = 8, m_rails = 1, m_nout = 8, m_tacc = 0;
  logic [7:0]  m_op = '0;
  logic        m_ha = 1'b0;
  logic [23:0] m_ad = '0;
  logic        prev_sck = 1'b0, prev_cs = 1'b1;
  int          mg, mbpg, mbi, mk;
  logic [3:0]  mv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Monitor + flash responder, sampling 2 time units after each rising clk edge.
  initial begin
    forever begin
      @(posedge clk); #2;
      cyc++;
      if (prev_cs && !cs_n) begin
        nrises = 0; tx_val = '0; oe_bad = 0; vcount = 0; rx_q.delete();
        t_csfall = cyc; t_first_rise = -1; t_csrise = -1; t_ready = -1;
      end
      if (!prev_cs && cs_n) t_csrise = cyc;
      if (cmd_ready && t_ready < 0 && t_csrise >= 0) t_ready = cyc;
      if (!prev_sck && sck) begin
        nrises++;
        if (t_first_rise < 0) t_first_rise = cyc;
        if (nrises <= m_nout) tx_val = {tx_val[30:0], io_out[0]};
        if (io_oe !== ((nrises <= m_nout) ? 4'b0001 : 4'b0000) || io_out[3:1] !== 3'b000)
          oe_bad++;
      end
      if (prev_sck && !sck) begin
        t_last_fall = cyc;
        mg = nrises - m_pre;
        mbpg = 8 / m_rails;
        if (mg >= 0 && (mg / mbpg) < m_data.size()) begin
          mbi = mg / mbpg;
          mk  = mg % mbpg;
          mv  = 4'((int'(m_data[mbi]) >> (8 - m_rails*(mk+1))) & ((1 << m_rails) - 1));
          case (m_rails)
            1:       io_in = {2'b00, mv[0], 1'b0};
            2:       io_in = {2'b00, mv[1:0]};
            default: io_in = mv;
          endcase
        end else begin
          io_in = 4'($urandom);
        end
      end
      case (ready_mode)
        0:       rdata_ready = 1'b1;
        1:       rdata_ready = 1'($urandom_range(0, 1));
        default: rdata_ready = 1'b0;
      endcase
      if (rdata_valid) vcount++;
      if (rdata_valid && rdata_ready && rst_b) rx_q.push_back(rdata);
      prev_sck = sck;
      prev_cs  = cs_n;
    end
  end

  task automatic start_txn(input logic [7:0] op, input logic ha, input logic [23:0] ad,
                           input logic [3:0] dm, input logic [1:0] md);
    m_rails = (md == 2'd1) ? 2 : (md == 2'd2) ? 4 : 1;
    m_pre   = 8 + (ha ? 24 : 0) + int'(dm);
    m_nout  = ha ? 32 : 8;
    m_op = op; m_ha = ha; m_ad = ad;
    @(negedge clk);
    check("cmd_ready_idle", 32'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_opcode = op; cmd_has_addr = ha; cmd_addr = ad;
    cmd_dummy = dm; cmd_mode = md; cmd_len = LEN_W'(m_data.size());
    m_tacc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("cs_n_T1", 32'(cs_n), 0);
    check("busy_T1", 32'(busy), 1);
    check("io0_T1", 32'(io_out[0]), 32'(op[7]));
    check("sck_T1", 32'(sck), 0);
  endtask

  task automatic finish_txn();
    int n;
    n = 0;
    while (!cmd_ready && n < 5000) begin @(negedge clk); n++; end
    check("txn_timeout", 32'(cmd_ready), 1);
    ready_mode = 0;
    n = 0;
    while (rdata_valid && n < 20) begin @(negedge clk); n++; end
    check("drain", 32'(rdata_valid), 0);
    check("rises", nrises, m_pre + m_data.size() * 8 / m_rails);
    check("tx_bits", tx_val, m_ha ? {m_op, m_ad} : {24'd0, m_op});
    check("oe_bad", oe_bad, 0);
    check("cs_fall_lat", t_csfall - m_tacc, 1);
    check("first_rise", t_first_rise - m_tacc, 1 + CLK_DIV);
    check("cs_rise_lat", t_csrise - t_last_fall, CLK_DIV);
    check("ready_lat", t_ready - t_csrise, 2 * CLK_DIV);
    check("rx_count", rx_q.size(), m_data.size());
    for (int i = 0; i < m_data.size() && i < rx_q.size(); i++)
      check("rx_byte", 32'(rx_q[i]), 32'(m_data[i]));
    if (m_data.size() == 0) check("no_rdata", vcount, 0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(cs_n), 1);
    check("rst_sck", 32'(sck), 0);
    check("rst_io_oe", 32'(io_oe), 0);
    check("rst_io_out", 32'(io_out), 0);
    check("rst_rvalid", 32'(rdata_valid), 0);
    check("rst_rdata", 32'(rdata), 0);
    check("rst_busy", 32'(busy), 0);
    rst_b = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 1);

    // Single read.
    m_data = '{8'hA5, 8'h3C};
    ready_mode = 0;
    start_txn(8'h03, 1'b1, 24'h012345, 4'd0, 2'd0);
    finish_txn();

    // Quad read with dummy cycles.
    m_data = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    start_txn(8'hEB, 1'b1, 24'($urandom), 4'd8, 2'd2);
    finish_txn();

    // Dual read.
    m_data = '{8'h96};
    start_txn(8'h3B, 1'b1, 24'($urandom), 4'd8, 2'd1);
    finish_txn();

    // Backpressure: consumer stalls while the second byte is in flight.
    m_data.delete();
    for (int i = 0; i < 3; i++) m_data.push_back(8'($urandom));
    ready_mode = 2;
    start_txn(8'hEB, 1'b1, 24'($urandom), 4'd8, 2'd2);
    n = 0;
    while (!rdata_valid && n < 2000) begin @(negedge clk); n++; end
    check("bp_valid", 32'(rdata_valid), 1);
    repeat (20) @(negedge clk);
    check("bp_rises", nrises, m_pre + 3);
    check("bp_sck", 32'(sck), 0);
    check("bp_cs", 32'(cs_n), 0);
    check("bp_rdata", 32'(rdata), 32'(m_data[0]));
    ready_mode = 0;
    finish_txn();

    // Randomized reads with random consumer backpressure.
    for (int r = 0; r < 6; r++) begin
      m_data.delete();
      n = $urandom_range(0, 4);
      for (int i = 0; i < n; i++) m_data.push_back(8'($urandom));
      ready_mode = 1;
      start_txn(8'($urandom), 1'($urandom), 24'($urandom), 4'($urandom), 2'($urandom));
      finish_txn();
    end

    // Reset during the address phase, then a bare opcode with no data.
    m_data.delete();
    ready_mode = 0;
    start_txn(8'h0B, 1'b1, 24'($urandom), 4'd8, 2'd0);
    n = 0;
    while (nrises < 15 && n < 500) begin @(negedge clk); n++; end
    check("reach_addr", 32'(nrises >= 15), 1);
    rst_b = 1'b0;
    @(negedge clk);
    check("mid_rst_cs_n", 32'(cs_n), 1);
    check("mid_rst_sck", 32'(sck), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_io_oe", 32'(io_oe), 0);
    rst_b = 1'b1;
    @(negedge clk);
    m_data.delete();
    start_txn(8'h06, 1'b0, 24'h000000, 4'd0, 2'd0);
    finish_txn();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/spi_flash_host.md
# spi_flash_host

Synthesizable SPI NOR-flash read initiator: accepts one read command at a time, then issues opcode, address and dummy cycles, and returns data bytes over a 1-, 2- or 4-rail bus. It is the host end of the link whose responder drives data after each falling `sck` edge, 8/rails falling edges per byte. It sits between the boot/fetch logic and the SPI pads, and data returns on a valid/ready byte stream with backpressure.

## Interface
- `CLK_DIV`, 2: `sck` half-period in `clk` cycles; legal range ≥1.
- `LEN_W`, 16: width of the byte-count field.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_b`  in  1  synchronous, active-low reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_opcode`  in  8  flash opcode; sent MSB first on io[0].
- `cmd_has_addr`  in  1  send the 24-bit address phase.
- `cmd_addr`  in  24  address; sent MSB first on io[0].
- `cmd_dummy`  in  4  number of dummy `sck` cycles (0–15).
- `cmd_mode`  in  2  data-phase rails: 0 = single, 1 = dual, 2 = quad, 3 = treated as single.
- `cmd_len`  in  LEN_W  bytes to read; 0 means no data phase.
- `rdata`  out  8  returned byte.
- `rdata_valid`  out  1  `rdata` holds an unconsumed byte.
- `rdata_ready`  in  1  consumer accepts the byte.
- `busy`  out  1  transaction in progress (`cs_n` low or in the hold state).
- `sck`  out  1  SPI clock, mode 0 (idles low).
- `cs_n`  out  1  chip select, active low.
- `io_out`  out  4  pad output data.
- `io_oe`  out  4  pad output enables.
- `io_in`  in  4  pad input data.

## Operation
- States: IDLE → CMD → ADDR (skipped if `!cmd_has_addr`) → DUMMY (skipped if `cmd_dummy == 0`) → DATA (skipped if `cmd_len == 0`) → END → HOLD → IDLE.
- **Accept.** A command is accepted on the cycle with `cmd_valid && cmd_ready`. All `cmd_*` fields are latched on that cycle.
- **Output changes.** The host changes outputs only while `sck` is low. The first bit is presented with `cs_n` falling. Each later bit is presented on the `clk` cycle in which `sck` falls.
- **Input sampling.** The host samples `io_in` on the `clk` cycle in which `sck` rises.
- **CMD and ADDR phases.** `io_oe = 4'b0001`. Output on `io_out[0]`: 8 opcode bits, then 24 address bits. `io_out[3:1] = 0`.
- **DUMMY and DATA phases.** `io_oe = 0`.
- **Per-rising-edge capture in DATA.** Each rising edge shifts in one group of bits:
  - single: `io_in[1]`
  - dual: `io_in[1:0]`
  - quad: `io_in[3:0]`, with `io_in[3]` as the most significant bit of the group.
  - Bytes are assembled MSB first. One byte takes 8/rails rising edges (8, 4 or 2).
- **Byte completion.** On the rising edge that completes a byte, the byte is copied to `rdata` and `rdata_valid` rises on the next cycle. `rdata_valid` clears on the cycle of `rdata_valid && rdata_ready`.
- **Backpressure.** The shift register forms a second byte buffer. If the rising edge that would complete the next byte arrives while `rdata_valid && !rdata_ready`:
  - `sck` stays low and the divider counter freezes;
  - clocking resumes on the cycle after the handshake;
  - no byte is dropped or duplicated.
- **Byte counter.** Counts delivered bytes. DATA exits after `cmd_len` completions; no further `sck` edges are issued.
- **END.** `sck` low for `CLK_DIV` cycles, then `cs_n` rises.
- **HOLD.** `cs_n` high for `2*CLK_DIV` cycles (deselect time), then IDLE. A pending `rdata` may still be outstanding when IDLE is entered.
- **Reset, including mid-transaction.** On the clock edge with `rst_b` low, all outputs and state take their reset values and the partial byte is discarded. Reset values:
  - `sck = 0`, `cs_n = 1`, `io_oe = 0`, `io_out = 0`
  - `rdata = 0`, `rdata_valid = 0`, `busy = 0`
  - state IDLE, so `cmd_ready = 1` on the first cycle after reset.

## Timing
- Accept cycle T:
  - At T+1: `cs_n = 0`, `busy = 1`, opcode bit 7 on `io_out[0]`, `sck = 0`.
  - At T+1+CLK_DIV: first `sck` rise.
- `sck` period is `2*CLK_DIV` `clk` cycles, 50% duty, except during backpressure stalls.
- Total `sck` rising edges per transaction = 8 + (24 if address) + `cmd_dummy` + `cmd_len*8/rails`.
- The last captured byte reaches `rdata_valid` one cycle after the final `sck` rise.
- `cs_n` rises `CLK_DIV` cycles after the final `sck` fall. `cmd_ready` returns `2*CLK_DIV` cycles after `cs_n` rises.
- A new `cmd_valid` during a transaction is ignored until IDLE. The command may be accepted on the first IDLE cycle, back to back.
- All outputs are registered, except `cmd_ready` (decoded from state).

## Test plan
- **Reset values.** Hold `rst_b = 0` 3 cycles → `cs_n = 1`, `sck = 0`, `io_oe = 0`, `rdata_valid = 0`; `cmd_ready = 1` on the first cycle after release.
- **Single read, CLK_DIV = 2.** Opcode 0x03, address 0x012345, 0 dummy, `cmd_len = 2`, model returns 0xA5, 0x3C → `io_out[0]` serialises 0x03 then 0x012345 over 32 rises; `rdata` = 0xA5 then 0x3C; 48 rises total; `cs_n` high 2 cycles after the last fall.
- **Quad read.** Opcode 0xEB, 8 dummy, `cmd_mode = 2`, `cmd_len = 4`, data 0xDE 0xAD 0xBE 0xEF → 2 rises per byte, `io_oe = 0` from the first dummy cycle, bytes delivered in order.
- **Dual read, `cmd_mode = 1`, `cmd_len = 1`.** Responder drives 0x96 as 2-bit groups 10, 01, 01, 10 → `rdata = 0x96` after 4 data rises.
- **Backpressure.** Quad read of 3 bytes with `rdata_ready = 0` for 20 cycles → `sck` frozen low before the second byte's final rise; after `rdata_ready = 1`, exactly 3 bytes are received, in order.
- **Mid-transaction reset and no-data command.** Assert `rst_b = 0` during ADDR → next cycle `cs_n = 1`, `sck = 0`. Then send opcode 0x06 with `cmd_has_addr = 0`, `cmd_len = 0` → exactly 8 rises, no `rdata_valid`.
